// File: rtl/pim_op_sequencer.sv
// Upstream controller for the PIM DataPath. It reads two operands, loads them into
// DataPath reg 0/1, runs one opcode and writes the result back, one command per 6 cycles.
module pim_op_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_src_a_i,
  input  logic [ADDR_W-1:0] cmd_src_b_i,
  input  logic [ADDR_W-1:0] cmd_dst_i,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,

  output logic              dp_reg_select_o,
  output logic [DATA_W-1:0] dp_load_data_o,
  output logic              dp_load_enable_o,
  output logic [1:0]        dp_opcode_o,
  input  logic [DATA_W-1:0] dp_out_i,

  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StLdA  = 3'd2;
  localparam logic [2:0] StLdB  = 3'd3;
  localparam logic [2:0] StExec = 3'd4;
  localparam logic [2:0] StWb   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
    end
  end

  // The command is only captured in idle, so fields stay frozen for the whole operation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    dst_d   = dst_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StRdA;
          op_d    = cmd_op_i;
          src_a_d = cmd_src_a_i;
          src_b_d = cmd_src_b_i;
          dst_d   = cmd_dst_i;
        end
      end
      StRdA:   state_d = StLdA;
      StLdA:   state_d = StLdB;
      StLdB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are pure decodes of state, so an asynchronous reset clears them immediately.
  always_comb begin
    cmd_ready_o      = 1'b0;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    mem_addr_o       = '0;
    mem_rd_en_o      = 1'b0;
    mem_wr_en_o      = 1'b0;
    mem_wdata_o      = '0;
    dp_reg_select_o  = 1'b0;
    dp_load_data_o   = '0;
    dp_load_enable_o = 1'b0;
    dp_opcode_o      = 2'b00;
    case (state_q)
      StRdA: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = src_a_q;
      end
      StLdA: begin
        dp_load_data_o   = mem_rdata_i;
        dp_load_enable_o = 1'b1;
        mem_rd_en_o      = 1'b1;
        mem_addr_o       = src_b_q;
      end
      StLdB: begin
        dp_load_data_o   = mem_rdata_i;
        dp_reg_select_o  = 1'b1;
        dp_load_enable_o = 1'b1;
      end
      StExec: begin
        dp_opcode_o = op_q;
      end
      StWb: begin
        dp_opcode_o = op_q;
        mem_wr_en_o = 1'b1;
        mem_addr_o  = dst_q;
        mem_wdata_o = dp_out_i;
        done_o      = 1'b1;
      end
      default: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pim_op_sequencer.sv
// Scoreboard bench for pim_op_sequencer with a synchronous-read memory and a DataPath model
// (00 add, 01 sub, 10 and, 11 or).
module tb_pim_op_sequencer;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        sel;
    logic        le;
    logic [31:0] ld;
    logic [1:0]  op;
  } ovec_t;

  typedef struct packed {
    int    cyc;
    ovec_t v;
  } ent_t;

  localparam ovec_t IdleV = {1'b1, {($bits(ovec_t) - 1){1'b0}}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata;
  logic        dp_reg_select, dp_load_enable;
  logic [31:0] dp_load_data;
  logic [1:0]  dp_opcode;
  logic [31:0] dp_out;
  logic        busy, done;

  logic [31:0] mem [0:255];
  logic [31:0] r0 = '0, r1 = '0;
  int          cyc = 0;
  int          writes = 0;
  int          checks = 0;
  int          failures = 0;
  ent_t        exp_q[$];
  ovec_t       act;

  pim_op_sequencer #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_src_a_i     (cmd_src_a),
    .cmd_src_b_i     (cmd_src_b),
    .cmd_dst_i       (cmd_dst),
    .mem_addr_o      (mem_addr),
    .mem_rd_en_o     (mem_rd_en),
    .mem_rdata_i     (mem_rdata),
    .mem_wr_en_o     (mem_wr_en),
    .mem_wdata_o     (mem_wdata),
    .dp_reg_select_o (dp_reg_select),
    .dp_load_data_o  (dp_load_data),
    .dp_load_enable_o(dp_load_enable),
    .dp_opcode_o     (dp_opcode),
    .dp_out_i        (dp_out),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      writes <= writes + 1;
    end
    if (dp_load_enable) begin
      if (dp_reg_select) r1 <= dp_load_data;
      else r0 <= dp_load_data;
    end
  end

  always_comb begin
    case (dp_opcode)
      2'b00:   dp_out = r0 + r1;
      2'b01:   dp_out = r0 - r1;
      2'b10:   dp_out = r0 & r1;
      default: dp_out = r0 | r1;
    endcase
  end

  assign act = {cmd_ready, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
                dp_reg_select, dp_load_enable, dp_load_data, dp_opcode};

  // Monitor: every non-idle output cycle must match the next expected step.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && act != IdleV) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d actual=%h required=idle", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== act) begin
          failures++;
          $display("FAIL seq_step cyc=%0d actual=%h required=%h at cyc %0d",
                   cyc, act, e.v, e.cyc);
        end
      end
    end
  end

  function automatic ovec_t mk(logic done_e, logic rd, logic wr, logic [7:0] addr,
                               logic [31:0] wdata, logic sel, logic le, logic [31:0] ld,
                               logic [1:0] op);
    ovec_t v;
    v.ready = 1'b0;
    v.busy  = 1'b1;
    v.done  = done_e;
    v.rd    = rd;
    v.wr    = wr;
    v.addr  = addr;
    v.wdata = wdata;
    v.sel   = sel;
    v.le    = le;
    v.ld    = ld;
    v.op    = op;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] actual, input logic [31:0] req);
    checks++;
    if (actual !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, actual, req);
    end
  endtask

  // Present a command from a negedge; returns one delta after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] res, input bit keep);
    int t;
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src_a = a;
    cmd_src_b = b;
    cmd_dst   = d;
    guard = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=not_ready required=ready");
        cmd_valid = 1'b0;
        return;
      end
    end
    t = cyc + 1;
    exp_q.push_back('{t,     mk(0, 1, 0, a, '0, 0, 0, '0, 2'b00)});
    exp_q.push_back('{t + 1, mk(0, 1, 0, b, '0, 0, 1, va, 2'b00)});
    exp_q.push_back('{t + 2, mk(0, 0, 0, '0, '0, 1, 1, vb, 2'b00)});
    exp_q.push_back('{t + 3, mk(0, 0, 0, '0, '0, 0, 0, '0, op)});
    exp_q.push_back('{t + 4, mk(1, 0, 1, d, res, 0, 0, '0, op)});
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h11223344;
    mem[8'h30] = 32'h00000005;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h42] = 32'hCAFEF00D;

    #3;
    checks++;
    if (act !== IdleV) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=%h", act, IdleV);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic op and opcode sweep.
    issue(2'b01, 8'h10, 8'h11, 8'h20, 32'h44332211, 32'h11223344, 32'h3310EECD, 0);
    drain();
    issue(2'b00, 8'h10, 8'h11, 8'h22, 32'h44332211, 32'h11223344, 32'h55555555, 0);
    issue(2'b10, 8'h10, 8'h11, 8'h23, 32'h44332211, 32'h11223344, 32'h00222200, 0);
    issue(2'b11, 8'h10, 8'h11, 8'h24, 32'h44332211, 32'h11223344, 32'h55333355, 0);
    drain();
    check32("mem20_sub", mem[8'h20], 32'h3310EECD);
    check32("mem22_add", mem[8'h22], 32'h55555555);
    check32("mem23_and", mem[8'h23], 32'h00222200);
    check32("mem24_or",  mem[8'h24], 32'h55333355);

    // Busy rejection: second command held valid throughout the first.
    w0 = writes;
    issue(2'b00, 8'h10, 8'h11, 8'h26, 32'h44332211, 32'h11223344, 32'h55555555, 1);
    issue(2'b10, 8'h10, 8'h11, 8'h21, 32'h44332211, 32'h11223344, 32'h00222200, 0);
    drain();
    check32("busy_write_count", writes - w0, 32'd2);
    check32("mem26_first", mem[8'h26], 32'h55555555);
    check32("mem21_second", mem[8'h21], 32'h00222200);

    // Aliasing: both sources and destination identical.
    issue(2'b00, 8'h30, 8'h30, 8'h30, 32'h00000005, 32'h00000005, 32'h0000000A, 0);
    drain();
    check32("mem30_alias", mem[8'h30], 32'h0000000A);

    // Reset during LD_B.
    w0 = writes;
    issue(2'b00, 8'h10, 8'h11, 8'h40, 32'h44332211, 32'h11223344, 32'h55555555, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act !== IdleV) begin
      failures++;
      $display("FAIL reset_ldb_async actual=%h required=%h", act, IdleV);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check32("reset_ldb_no_write", writes - w0, 32'd0);
    check32("mem40_kept", mem[8'h40], 32'hDEADBEEF);
    issue(2'b11, 8'h10, 8'h11, 8'h41, 32'h44332211, 32'h11223344, 32'h55333355, 0);
    drain();
    check32("mem41_after_reset", mem[8'h41], 32'h55333355);

    // Reset in the writeback cycle before its edge.
    w0 = writes;
    issue(2'b01, 8'h10, 8'h11, 8'h42, 32'h44332211, 32'h11223344, 32'h3310EECD, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("reset_wb_wr_en", {31'b0, mem_wr_en}, 32'd0);
    checks++;
    if (act !== IdleV) begin
      failures++;
      $display("FAIL reset_wb_async actual=%h required=%h", act, IdleV);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check32("reset_wb_no_write", writes - w0, 32'd0);
    check32("mem42_kept", mem[8'h42], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pim_op_sequencer.md
Name: pim_op_sequencer

Overview:
- Upstream controller for the PIM DataPath.
- Accepts one operation command per handshake: opcode, two source addresses and a destination address.
- Reads both operands from a synchronous-read memory and loads them into DataPath register 0 and register 1.
- Drives the DataPath opcode, then writes the DataPath result back to memory at the destination address.

Parameters:
- DATA_W, 32, operand/result width (matches DataPath load_data/out).
- ADDR_W, 8, memory address width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  DataPath opcode for this command.
- cmd_src_a  in  ADDR_W  address of operand A (goes to DataPath reg 0).
- cmd_src_b  in  ADDR_W  address of operand B (goes to DataPath reg 1).
- cmd_dst  in  ADDR_W  result write address.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read request; data is returned on mem_rdata the next cycle.
- mem_rdata  in  DATA_W  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- dp_reg_select  out  1  DataPath reg_select.
- dp_load_data  out  DATA_W  DataPath load_data.
- dp_load_enable  out  1  DataPath load_enable, one-cycle pulse.
- dp_opcode  out  2  DataPath opcode.
- dp_out  in  DATA_W  DataPath result.
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse in the writeback cycle.

Behaviour:
- States: IDLE, RD_A, LD_A, LD_B, EXEC, WB. All outputs are decoded from the current state and the latched command.
- IDLE:
  - cmd_ready=1, busy=0, all other outputs 0.
  - cmd_valid=1 at a clock edge latches op/src_a/src_b/dst and moves to RD_A.
  - cmd_valid=0 stays in IDLE.
- RD_A: mem_rd_en=1, mem_addr=src_a. Moves to LD_A.
- LD_A:
  - dp_load_data=mem_rdata (operand A), dp_reg_select=0, dp_load_enable=1.
  - Same cycle: mem_rd_en=1, mem_addr=src_b.
  - Moves to LD_B.
- LD_B: dp_load_data=mem_rdata (operand B), dp_reg_select=1, dp_load_enable=1. Moves to EXEC.
- EXEC: dp_opcode=op; one full cycle for dp_out to settle. Moves to WB.
- WB:
  - dp_opcode=op held, mem_wr_en=1, mem_addr=dst, mem_wdata=dp_out, done=1.
  - Moves to IDLE.
- Outside EXEC/WB, dp_opcode=2'b00. Outside LD_A/LD_B, dp_load_data=0 and dp_load_enable=0; dp_reg_select=0 except in LD_B.
- Latency: command accepted at edge T; RD_A during T+1, LD_A T+2, LD_B T+3, EXEC T+4, WB T+5; cmd_ready high again in cycle T+6.
  - Throughput is one command per 6 cycles.
  - No back-to-back acceptance in the WB cycle.
- busy=1 in every non-IDLE state.
- cmd_ready=0 while busy. cmd_valid and command fields are ignored while busy; latched fields never change mid-operation.
- src_a==src_b: legal; two reads, the same value loads into both registers.
- dst equal to either source: legal; both reads complete before the write, so the old values are used.
- All opcodes 00..11 are legal and passed through unmodified.
- Address values use the full ADDR_W range with no wrap logic; the sequencer never increments addresses.
- Reset:
  - rst asserted at any time forces IDLE immediately (asynchronously), clears the latched command, and drives all outputs to 0 except cmd_ready=1.
  - Reset during WB suppresses the write; no partial load or writeback occurs after reset.
- Reset values: cmd_ready=1; busy, done, mem_rd_en, mem_wr_en, dp_load_enable, dp_reg_select=0; mem_addr, mem_wdata, dp_load_data, dp_opcode=0.

Test Plan:
- Basic op:
  - Stimulus: mem[8'h10]=32'h44332211, mem[8'h11]=32'h11223344; command op=2'b01, src_a=10, src_b=11, dst=20 at T.
  - Response: T+2 load 44332211 with reg_select=0; T+3 load 11223344 with reg_select=1; T+4 dp_opcode=01; T+5 write dp_out to 8'h20 with done=1; cmd_ready=1 at T+6.
- Opcode sweep: repeat the basic op for op=00, 10, 11 -> mem[dst] equals the DataPath model result for each opcode; dp_opcode is 00 outside EXEC/WB.
- Busy rejection: hold cmd_valid=1 with a second command (op=10, dst=21) continuously.
  - First command completes untouched.
  - Second is accepted at the T+6 edge; its write lands at T+11.
  - Exactly two writes occur.
- Aliasing:
  - src_a=src_b=dst=8'h30, mem[30]=32'h00000005.
  - Both loads carry 00000005; mem[30] is overwritten only in WB.
- Reset mid-op:
  - Assert rst during LD_B (T+3): outputs go to 0 asynchronously and cmd_ready=1; no write ever occurs.
  - A fresh command after release completes normally.
- Reset in WB: assert rst in the T+5 cycle before the edge -> mem_wr_en drops immediately and mem[dst] is unchanged.
